// File: rtl/apb_slave_regfile.sv
// APB4 slave register file: DEPTH words of WDATA bits, byte strobes, fixed wait states,
// PSLVERR on misaligned or out-of-range accesses.
module apb_slave_regfile #(
  parameter int unsigned WDATA       = 32,
  parameter int unsigned WADDR       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               i_PCLK,
  input  logic               i_PRESETn,
  input  logic               i_PSELx,
  input  logic               i_PENABLE,
  input  logic               i_PWRITE,
  input  logic [WADDR-1:0]   i_PADDR,
  input  logic [WDATA-1:0]   i_PWDATA,
  input  logic [WDATA/8-1:0] i_PSTRB,
  output logic               o_PREADY,
  output logic               o_PSLVERR,
  output logic [WDATA-1:0]   o_PRDATA
);

  localparam int unsigned NumBytes = WDATA / 8;
  localparam int unsigned LsbBits  = $clog2(NumBytes);
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WADDR-1:0] LsbMask   = WADDR'(NumBytes - 1);
  localparam logic [3:0]       WaitLimit = 4'(WAIT_CYCLES);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic              err_q;
  logic [IdxW-1:0]   idx_q;
  logic [WDATA-1:0]  mem_q [DEPTH];

  logic [WADDR-1:0]  word_addr;
  logic              addr_err;
  logic              ready;

  // Out-of-range indices are flagged here, so only the low IdxW bits need latching.
  always_comb begin
    word_addr = i_PADDR >> LsbBits;
    addr_err  = (|(i_PADDR & LsbMask)) || (32'(word_addr) >= DEPTH);
  end

  assign ready = (state_q == StAccess) && (cnt_q == WaitLimit);

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_PSELx && !i_PENABLE) begin
            state_q <= StAccess;
            write_q <= i_PWRITE;
            err_q   <= addr_err;
            idx_q   <= word_addr[IdxW-1:0];
            cnt_q   <= '0;
          end
        end
        StAccess: begin
          if (!i_PSELx) begin
            // Master dropped select mid-transfer: abandon silently.
            state_q <= StIdle;
          end else begin
            if (cnt_q < WaitLimit) begin
              cnt_q <= cnt_q + 4'd1;
            end
            if (ready && i_PENABLE) begin
              state_q <= StIdle;
              if (write_q && !err_q) begin
                for (int b = 0; b < int'(NumBytes); b++) begin
                  if (i_PSTRB[b]) begin
                    mem_q[idx_q][8*b +: 8] <= i_PWDATA[8*b +: 8];
                  end
                end
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_PREADY  = ready;
    o_PSLVERR = ready && err_q;
    o_PRDATA  = '0;
    if (ready && !write_q && !err_q) begin
      o_PRDATA = mem_q[idx_q];
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with two wait states, one with none.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        rdy_a, err_a, rdy_b, err_b;
  logic [31:0] rd_a, rd_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_regfile #(.WDATA(32), .WADDR(8), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .i_PCLK    (clk),
    .i_PRESETn (rst_n),
    .i_PSELx   (psel_a),
    .i_PENABLE (penable),
    .i_PWRITE  (pwrite),
    .i_PADDR   (paddr),
    .i_PWDATA  (pwdata),
    .i_PSTRB   (pstrb),
    .o_PREADY  (rdy_a),
    .o_PSLVERR (err_a),
    .o_PRDATA  (rd_a)
  );

  apb_slave_regfile #(.WDATA(32), .WADDR(8), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .i_PCLK    (clk),
    .i_PRESETn (rst_n),
    .i_PSELx   (psel_b),
    .i_PENABLE (penable),
    .i_PWRITE  (pwrite),
    .i_PADDR   (paddr),
    .i_PWDATA  (pwdata),
    .i_PSTRB   (pstrb),
    .o_PREADY  (rdy_b),
    .o_PSLVERR (err_b),
    .o_PRDATA  (rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer on instance a (b=0) or b (b=1); outputs sampled on negedges.
  task automatic xfer(input bit b, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_acc);
    int   acc;
    logic rdy, err;
    logic [31:0] rd;
    @(negedge clk);
    psel_a = !b; psel_b = b; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    acc = 0;
    rdy = 1'b0;
    while (!rdy && acc < 20) begin
      acc++;
      rdy = b ? rdy_b : rdy_a;
      err = b ? err_b : err_a;
      rd  = b ? rd_b : rd_a;
      if (!rdy) begin
        chk("rdata_before_ready", rd, 32'h0);
        chk("slverr_before_ready", {31'b0, err}, 32'h0);
        @(negedge clk);
      end
    end
    chk($sformatf("access_cycles_%h", addr), acc, exp_acc);
    chk($sformatf("rdata_%h", addr), rd, exp_rd);
    chk($sformatf("slverr_%h", addr), {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic go_idle();
    @(negedge clk);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int t0;
    repeat (2) @(negedge clk);
    chk("reset_pready", {31'b0, rdy_a}, 32'h0);
    chk("reset_pslverr", {31'b0, err_a}, 32'h0);
    chk("reset_prdata", rd_a, 32'h0);
    rst_n = 1'b1;

    // 1: full write, read back
    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3);
    // 2: partial strobes, empty strobe
    xfer(0, 1, 8'h10, 32'h1234CAFE, 4'b0011, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADCAFE, 1'b0, 3);
    xfer(0, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADCAFE, 1'b0, 3);
    // 3: out-of-range and misaligned accesses
    xfer(0, 1, 8'h40, 32'h55555555, 4'hF, 32'h0, 1'b1, 3);
    xfer(0, 1, 8'h11, 32'h66666666, 4'hF, 32'h0, 1'b1, 3);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADCAFE, 1'b0, 3);
    xfer(0, 0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1, 3);
    go_idle();

    // 4: reset during the second wait cycle of a write
    @(negedge clk);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    chk("rst_wait1_pready", {31'b0, rdy_a}, 32'h0);
    @(negedge clk);
    chk("rst_wait2_pready", {31'b0, rdy_a}, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("rst_assert_pready", {31'b0, rdy_a}, 32'h0);
    @(negedge clk);
    chk("rst_hold_pready", {31'b0, rdy_a}, 32'h0);
    @(negedge clk);
    chk("rst_hold2_pready", {31'b0, rdy_a}, 32'h0);
    psel_a = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    xfer(0, 1, 8'h08, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 3);
    go_idle();

    // 5: zero wait states, back-to-back over the whole array
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      xfer(1, 1, 8'(4 * i), 32'hA5A50000 | 32'(i * 17), 4'hF, 32'h0, 1'b0, 1);
    end
    chk("b2b_write_clocks", cyc - t0, 32);
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      xfer(1, 0, 8'(4 * i), 32'h0, 4'h0, 32'hA5A50000 | 32'(i * 17), 1'b0, 1);
    end
    chk("b2b_read_clocks", cyc - t0, 32);
    go_idle();

    // PSEL dropped during ACCESS: no write, no completion afterwards
    @(negedge clk);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge clk);
    psel_b = 1'b0; penable = 1'b1;
    @(negedge clk);
    chk("abort_idle_pready", {31'b0, rdy_b}, 32'h0);
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 32'hA5A50000, 1'b0, 1);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
